// File: rtl/mfp_ahb_gpio_nbot.sv
// AHB-Lite GPIO slave for N_BOT Rojobot channels, with LEDs, keyboard, game control and hit inputs.
// Rising edges on bot-update and hit levels latch into W1C status flags that drive a maskable IRQ.
module mfp_ahb_gpio_nbot #(
    parameter int N_BOT  = 2,
    parameter int N_LED  = 16,
    parameter int KEYB_W = 16,
    parameter int N_HIT  = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [3:0]           HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [31:0]          HWDATA,
    input  logic                 HWRITE,
    input  logic                 HSEL,
    output logic [31:0]          HRDATA,
    output logic [N_LED-1:0]     IO_LED,
    input  logic [KEYB_W-1:0]    IO_keyb,
    output logic [15:0]          IO_GameCtrl,
    input  logic [N_HIT-1:0]     IO_HIT,
    input  logic [32*N_BOT-1:0]  IO_BotInfo,
    input  logic [N_BOT-1:0]     IO_BotUpdt_Sync,
    output logic [8*N_BOT-1:0]   IO_BotCtrl,
    output logic [N_BOT-1:0]     IO_INT_ACK,
    output logic                 IO_IRQ
);

    localparam int NS = N_BOT + N_HIT;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    localparam logic [3:0] IDX_LED    = 4'd0;
    localparam logic [3:0] IDX_KEYB   = 4'd1;
    localparam logic [3:0] IDX_GAME   = 4'd2;
    localparam logic [3:0] IDX_STATUS = 4'd3;
    localparam logic [3:0] IDX_IRQEN  = 4'd4;
    localparam logic [3:0] IDX_RAW    = 4'd5;

    logic [3:0]    haddr_d;
    logic [1:0]    htrans_d;
    logic          hwrite_d;
    logic          hsel_d;
    logic          wr_en;
    logic          rd_en;
    logic          wr_status;
    logic [NS-1:0] status;
    logic [NS-1:0] irq_en;
    logic [NS-1:0] raw;
    logic [NS-1:0] raw_d;
    logic [NS-1:0] rise;
    logic [NS-1:0] clr;
    logic [31:0]   rd_mux;
    logic          unused_hwdata;

    assign unused_hwdata = ^HWDATA;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_d  <= '0;
            htrans_d <= HTRANS_IDLE;
            hwrite_d <= 1'b0;
            hsel_d   <= 1'b0;
        end else begin
            haddr_d  <= HADDR;
            htrans_d <= HTRANS;
            hwrite_d <= HWRITE;
            hsel_d   <= HSEL;
        end
    end

    assign wr_en     = hsel_d && hwrite_d && (htrans_d != HTRANS_IDLE);
    assign rd_en     = HSEL && !HWRITE && (HTRANS != HTRANS_IDLE);
    assign wr_status = wr_en && (haddr_d == IDX_STATUS);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            IO_LED      <= '0;
            IO_GameCtrl <= '0;
            irq_en      <= '0;
            IO_BotCtrl  <= '0;
        end else if (wr_en) begin
            case (haddr_d)
                IDX_LED:   IO_LED      <= HWDATA[N_LED-1:0];
                IDX_GAME:  IO_GameCtrl <= HWDATA[15:0];
                IDX_IRQEN: irq_en      <= HWDATA[NS-1:0];
                default: begin
                    for (int k = 0; k < N_BOT; k++) begin
                        if (haddr_d == 4'(8 + 2*k))
                            IO_BotCtrl[8*k +: 8] <= HWDATA[7:0];
                    end
                end
            endcase
        end
    end

    // Edge capture: delayed copy resets low so a level already high at release counts as an edge.
    assign raw  = {IO_HIT, IO_BotUpdt_Sync};
    assign rise = raw & ~raw_d;
    assign clr  = wr_status ? HWDATA[NS-1:0] : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            raw_d      <= '0;
            status     <= '0;
            IO_INT_ACK <= '0;
            IO_IRQ     <= 1'b0;
        end else begin
            raw_d      <= raw;
            status     <= (status & ~clr) | rise;
            IO_INT_ACK <= wr_status ? HWDATA[N_BOT-1:0] : '0;
            IO_IRQ     <= |(status & irq_en);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (HADDR)
            IDX_LED:    rd_mux[N_LED-1:0]  = IO_LED;
            IDX_KEYB:   rd_mux[KEYB_W-1:0] = IO_keyb;
            IDX_GAME:   rd_mux[15:0]       = IO_GameCtrl;
            IDX_STATUS: rd_mux[NS-1:0]     = status;
            IDX_IRQEN:  rd_mux[NS-1:0]     = irq_en;
            IDX_RAW:    rd_mux[NS-1:0]     = raw;
            default: begin
                for (int k = 0; k < N_BOT; k++) begin
                    if (HADDR == 4'(8 + 2*k))
                        rd_mux[7:0] = IO_BotCtrl[8*k +: 8];
                    else if (HADDR == 4'(9 + 2*k))
                        rd_mux = IO_BotInfo[32*k +: 32];
                end
            end
        endcase
    end

    // Read data is captured at the address-phase edge, so a read right after a write sees the old value.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            HRDATA <= '0;
        else if (rd_en)
            HRDATA <= rd_mux;
    end

endmodule
